interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0100: handler vector base address.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port NON_maskable_interrupt  in  1  NMI; rising-edge sensitive.
REQ-005 SHALL have port interrupt_r  in  4  level-sensitive maskable requests; bit 0 highest priority.
REQ-006 SHALL have port CPU_busy  in  1  high while CPU is mid-instruction (not at an instruction boundary).
REQ-007 SHALL have port mask_we  in  1  mask write strobe.
REQ-008 SHALL have port mask_wdata  in  4  new enable mask; 1 = line enabled.
REQ-009 SHALL have port int_ack  in  1  CPU accepts the presented interrupt.
REQ-010 SHALL have port eret  in  1  CPU returns from handler.
REQ-011 SHALL have port int_req  out  1  interrupt request to CPU.
REQ-012 SHALL have port int_cause  out  3  0-3 = maskable line index, 4 = NMI, 7 = none.
REQ-013 SHALL have port int_vector  out  32  handler address.
REQ-014 SHALL have port in_service  out  1  handler currently executing.
REQ-015 SHALL have port mask_q  out  4  current enable mask.

Function
REQ-016 SHALL capture NMI rising edge (registered previous value) into nmi_pend; nmi_pend cleared only on int_ack of an NMI; edges while nmi_pend set are merged.
REQ-017 SHALL form candidate set = nmi_pend OR any(interrupt_r & mask_q); priority NMI > line0 > line1 > line2 > line3.
REQ-018 SHALL update mask_q from mask_wdata on clock with mask_we high, any state; effect visible next cycle; NMI never masked.
REQ-019 SHALL implement FSM IDLE, WAIT_BOUNDARY, REQUEST, SERVICE.
REQ-020 IDLE: candidate present -> WAIT_BOUNDARY.
REQ-021 WAIT_BOUNDARY: no candidate -> IDLE; candidate and CPU_busy=0 -> latch winner into int_cause/int_vector, -> REQUEST; CPU_busy=1 -> stay.
REQ-022 REQUEST: int_req=1; int_cause/int_vector held stable, even if source deasserts or mask changes; int_ack -> SERVICE.
REQ-023 SERVICE: in_service=1, int_req=0, cause/vector held; eret -> IDLE, int_cause=7 next cycle.
REQ-024 SHALL ignore int_ack outside REQUEST and eret outside SERVICE; no nesting (NMI arriving in SERVICE stays pending, served after eret).
REQ-025 int_vector SHALL equal VEC_BASE + {cause, 4'b0000} (32-bit, wrap-around modulo 2^32).
REQ-026 Latency: candidate first visible in IDLE at edge N with CPU_busy=0 -> int_req high after edge N+2.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 On reset_n low, immediately: state IDLE, int_req=0, in_service=0, int_cause=3'b111, int_vector=0, mask_q=4'b0000, nmi_pend=0, NMI edge register=0.
REQ-029 Reset mid-REQUEST or mid-SERVICE SHALL drop int_req/in_service asynchronously and discard pending NMI.
REQ-030 Release of reset_n SHALL require no further initialisation; first NMI edge after release is captured.

Structure
REQ-031 Shared package mips_int_pkg SHALL hold FSM state encodings, cause codes (CAUSE_NMI=4, CAUSE_NONE=7) and default VEC_BASE.
REQ-032 One sub-module nmi_edge_detect (edge register plus sticky pending flag with clear input) SHALL be used; arbitration and FSM stay in the top.

Verification
REQ-033 mask_we with 4'b0010, interrupt_r=4'b0010, CPU_busy=0 -> int_req after 2 edges, int_cause=1, int_vector=32'h0000_0110.
REQ-034 interrupt_r=4'b1111, mask=4'b1100 -> int_cause=2; then NMI edge in same cycle as candidate -> int_cause=4, int_vector=32'h0000_0140.
REQ-035 Candidate with CPU_busy=1 for 5 cycles -> int_req stays 0 until CPU_busy falls, asserts 1 edge later.
REQ-036 NMI pulse during SERVICE of line 0 -> int_req stays 0 until eret, then NMI request (cause 4) within 2 edges after IDLE.
REQ-037 Source deasserted during REQUEST -> int_req and int_cause held until int_ack; int_ack/eret issued in IDLE -> no state change.
REQ-038 reset_n low while in REQUEST -> int_req=0, int_cause=7, mask_q=0 without a clock edge.

Source files
------------

// File: rtl/mips_int_pkg.sv
// mips_int_pkg: shared FSM states, cause codes, default vector base and priority helper
package mips_int_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REQ, ST_SERV} state_e;
  localparam logic [2:0] CAUSE_NMI = 3'd4;
  localparam logic [2:0] CAUSE_NONE = 3'd7;
  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0100;
  // index of the lowest set bit (line 0 wins), CAUSE_NONE when empty
  function automatic logic [2:0] lowest_set(input logic [3:0] v);
    lowest_set = CAUSE_NONE;
    for (int i = 3; i >= 0; i--) if (v[i]) lowest_set = 3'(i);
  endfunction
endpackage

// File: rtl/nmi_edge_detect.sv
// nmi_edge_detect: NMI rising-edge capture into a sticky pending flag
// Ports: clk_i clock, rst_ni async active-low reset, nmi_i raw NMI,
//        clr_i clear pending (NMI acknowledged), pend_o pending flag
module nmi_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic nmi_i,
  input  logic clr_i,
  output logic pend_o
);
  logic prev_q, pend_q, pend_d;
  // while pending, new edges merge into the existing request
  assign pend_d = pend_q ? ~clr_i : (nmi_i & ~prev_q);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= nmi_i;
      pend_q <= pend_d;
    end
  end
  assign pend_o = pend_q;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised NMI + 4-line maskable interrupt controller
// Ports: clock, reset_n (async active-low), NON_maskable_interrupt (edge),
//        interrupt_r[3:0] (level, bit 0 highest), CPU_busy, mask_we/mask_wdata,
//        int_ack, eret in; int_req, int_cause, int_vector, in_service, mask_q out
module interrupt_controller
  import mips_int_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        NON_maskable_interrupt,
  input  logic [3:0]  interrupt_r,
  input  logic        CPU_busy,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  input  logic        int_ack,
  input  logic        eret,
  output logic        int_req,
  output logic [2:0]  int_cause,
  output logic [31:0] int_vector,
  output logic        in_service,
  output logic [3:0]  mask_q
);
  state_e state_q, state_d;
  logic [2:0] cause_q, cause_d, win;
  logic [31:0] vector_q, vector_d;
  logic [3:0] mask_d, live;
  logic req_q, srv_q, nmi_pend, nmi_clr, cand, latch;
  nmi_edge_detect u_nmi (
    .clk_i (clock),
    .rst_ni(reset_n),
    .nmi_i (NON_maskable_interrupt),
    .clr_i (nmi_clr),
    .pend_o(nmi_pend)
  );
  assign live = interrupt_r & mask_q;
  assign cand = nmi_pend | (|live);
  assign win = nmi_pend ? CAUSE_NMI : lowest_set(live);
  assign nmi_clr = (state_q == ST_REQ) & int_ack & (cause_q == CAUSE_NMI);
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = cand ? ST_WAIT : ST_IDLE;
      ST_WAIT: state_d = !cand ? ST_IDLE : (CPU_busy ? ST_WAIT : ST_REQ);
      ST_REQ:  state_d = int_ack ? ST_SERV : ST_REQ;
      ST_SERV: state_d = eret ? ST_IDLE : ST_SERV;
      default: state_d = ST_IDLE;
    endcase
  end
  // winner is frozen at the boundary; later source/mask changes cannot alter it
  assign latch = (state_q == ST_WAIT) & (state_d == ST_REQ);
  assign cause_d = latch ? win : ((state_q == ST_SERV) & eret) ? CAUSE_NONE : cause_q;
  assign vector_d = latch ? VEC_BASE + {25'd0, win, 4'd0} : vector_q;
  assign mask_d = mask_we ? mask_wdata : mask_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q <= 1'b0;
      srv_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      vector_q <= 32'd0;
      mask_q <= 4'd0;
    end else begin
      state_q <= state_d;
      req_q <= state_d == ST_REQ;
      srv_q <= state_d == ST_SERV;
      cause_q <= cause_d;
      vector_q <= vector_d;
      mask_q <= mask_d;
    end
  end
  assign int_req = req_q;
  assign in_service = srv_q;
  assign int_cause = cause_q;
  assign int_vector = vector_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed + random bench against a behavioural model
module tb_interrupt_controller;
  localparam logic [31:0] VB = 32'h0000_0100;
  logic clock = 1'b0, reset_n = 1'b0, NON_maskable_interrupt = 1'b0;
  logic [3:0] interrupt_r = 4'd0, mask_wdata = 4'd0;
  logic CPU_busy = 1'b0, mask_we = 1'b0, int_ack = 1'b0, eret = 1'b0;
  logic int_req, in_service;
  logic [2:0] int_cause;
  logic [31:0] int_vector;
  logic [3:0] mask_q;
  int total = 0, bad = 0;
  int m_phase;
  logic m_pend, m_prev;
  logic [3:0] m_mask;
  logic [2:0] m_cause;
  logic [31:0] m_vec;
  interrupt_controller #(.VEC_BASE(VB)) dut (
    .clock(clock), .reset_n(reset_n), .NON_maskable_interrupt(NON_maskable_interrupt),
    .interrupt_r(interrupt_r), .CPU_busy(CPU_busy), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_ack(int_ack), .eret(eret), .int_req(int_req),
    .int_cause(int_cause), .int_vector(int_vector), .in_service(in_service), .mask_q(mask_q)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_prev = 0; m_mask = 0; m_cause = 7; m_vec = 0;
  endtask
  // phases: 0 idle, 1 waiting for boundary, 2 requesting, 3 servicing
  task automatic model_edge();
    logic [2:0] w;
    logic any, np;
    int nph;
    if (!reset_n) begin
      model_reset();
      return;
    end
    any = m_pend || ((interrupt_r & m_mask) != 0);
    w = 7;
    if (m_pend) w = 4;
    else for (int i = 3; i >= 0; i--) if (interrupt_r[i] && m_mask[i]) w = 3'(i);
    np = m_pend ? !(m_phase == 2 && int_ack && m_cause == 4) : (NON_maskable_interrupt && !m_prev);
    nph = m_phase;
    if (m_phase == 0 && any) nph = 1;
    else if (m_phase == 1 && !any) nph = 0;
    else if (m_phase == 1 && !CPU_busy) begin
      nph = 2; m_cause = w; m_vec = VB + 32'(w) * 32'd16;
    end
    else if (m_phase == 2 && int_ack) nph = 3;
    else if (m_phase == 3 && eret) begin
      nph = 0; m_cause = 7;
    end
    m_phase = nph;
    m_pend = np;
    m_prev = NON_maskable_interrupt;
    if (mask_we) m_mask = mask_wdata;
  endtask
  task automatic check_model();
    chk("req", 32'(int_req), 32'(m_phase == 2));
    chk("srv", 32'(in_service), 32'(m_phase == 3));
    chk("cause", 32'(int_cause), 32'(m_cause));
    chk("mask", 32'(mask_q), 32'(m_mask));
    if (m_phase >= 2) chk("vec", int_vector, m_vec);
  endtask
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      model_edge();
      #1;
      check_model();
    end
  endtask
  task automatic async_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_req", 32'(int_req), 0);
    chk("rst_srv", 32'(in_service), 0);
    chk("rst_cause", 32'(int_cause), 7);
    chk("rst_vec", int_vector, 0);
    chk("rst_mask", 32'(mask_q), 0);
    reset_n = 1'b1;
  endtask
  initial begin
    model_reset();
    #12;
    chk("por_req", 32'(int_req), 0);
    chk("por_cause", 32'(int_cause), 7);
    chk("por_mask", 32'(mask_q), 0);
    reset_n = 1'b1;
    step();
    // mask write then line 1: request two edges after the mask lands
    mask_we = 1; mask_wdata = 4'b0010; interrupt_r = 4'b0010;
    step();
    mask_we = 0;
    step();
    chk("lat_early", 32'(int_req), 0);
    step();
    chk("lat_req", 32'(int_req), 1);
    chk("lat_cause", 32'(int_cause), 1);
    chk("lat_vec", int_vector, 32'h0000_0110);
    // source drops while requesting: request held
    interrupt_r = 0;
    mask_we = 1; mask_wdata = 4'b0000;
    step();
    mask_we = 0;
    step(2);
    chk("hold_req", 32'(int_req), 1);
    chk("hold_cause", 32'(int_cause), 1);
    int_ack = 1; step(); int_ack = 0;
    chk("ack_srv", 32'(in_service), 1);
    eret = 1; step(); eret = 0;
    chk("eret_cause", 32'(int_cause), 7);
    int_ack = 1; eret = 1; step(); int_ack = 0; eret = 0;
    chk("idle_ack_req", 32'(int_req), 0);
    chk("idle_eret_srv", 32'(in_service), 0);
    // mask 1100 over all lines -> line 2
    mask_we = 1; mask_wdata = 4'b1100; interrupt_r = 4'b1111;
    step(); mask_we = 0;
    step(2);
    chk("m1100_cause", 32'(int_cause), 2);
    int_ack = 1; step(); int_ack = 0;
    eret = 1; step(); eret = 0;
    // NMI edge arrives together with the line candidate
    NON_maskable_interrupt = 1;
    step(2);
    chk("nmi_cause", 32'(int_cause), 4);
    chk("nmi_vec", int_vector, 32'h0000_0140);
    int_ack = 1; step(); int_ack = 0;
    NON_maskable_interrupt = 0;
    eret = 1; interrupt_r = 0; step(); eret = 0;
    // CPU busy holds off the request
    mask_we = 1; mask_wdata = 4'b0001; CPU_busy = 1; step(); mask_we = 0;
    interrupt_r = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_hold", 32'(int_req), 0);
    end
    CPU_busy = 0;
    step();
    chk("busy_release", 32'(int_req), 1);
    chk("busy_cause", 32'(int_cause), 0);
    int_ack = 1; step(); int_ack = 0;
    // NMI during service waits for eret
    NON_maskable_interrupt = 1; step(); NON_maskable_interrupt = 0;
    step(3);
    chk("nest_req", 32'(int_req), 0);
    chk("nest_srv", 32'(in_service), 1);
    eret = 1; step(); eret = 0;
    step(2);
    chk("post_nmi_req", 32'(int_req), 1);
    chk("post_nmi_cause", 32'(int_cause), 4);
    async_reset();
    step(2);
    // randomized phase, occasional async reset
    for (int c = 0; c < 600; c++) begin
      interrupt_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) NON_maskable_interrupt = ~NON_maskable_interrupt;
      CPU_busy = $urandom_range(0, 1) == 1;
      mask_we = $urandom_range(0, 9) == 0;
      mask_wdata = 4'($urandom_range(0, 15));
      int_ack = $urandom_range(0, 2) == 0;
      eret = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 99) == 0) async_reset();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
